// File: rtl/eth_rx_addr_filter.sv
// rtl/eth_rx_addr_filter.sv - destination-MAC filter and frame gate between MAC RX stream and RX FIFO
// Header bytes are held in a small ring until the byte-5 decision, then released or discarded.
module eth_rx_addr_filter #(
    parameter bit ENABLE_MULTICAST = 1'b1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic [47:0]          local_mac,
    input  logic                 promisc,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] runt_count
);

    typedef enum logic [1:0] {ST_HDR, ST_PASS, ST_DROP} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [9:0]           mem_q [16];
    logic [3:0]           wr_ptr_q;
    logic [3:0]           sof_ptr_q;
    logic [3:0]           commit_ptr_q;
    logic [3:0]           rd_ptr_q;
    logic [2:0]           hdr_cnt_q;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] pass_q;
    logic [CNT_WIDTH-1:0] drop_q;
    logic [CNT_WIDTH-1:0] runt_q;

    logic [47:0]          dest;
    logic                 hit;
    logic                 wr_en;

    // Bytes 0..4 come from the ring, byte 5 straight from the input on the decision edge.
    assign dest = {mem_q[sof_ptr_q][9:2],
                   mem_q[sof_ptr_q + 4'd1][9:2],
                   mem_q[sof_ptr_q + 4'd2][9:2],
                   mem_q[sof_ptr_q + 4'd3][9:2],
                   mem_q[sof_ptr_q + 4'd4][9:2],
                   s_axis_tdata};

    assign hit   = promisc || (dest == local_mac) || (&dest) || (ENABLE_MULTICAST && dest[40]);
    assign wr_en = s_axis_tvalid && (state_q != ST_DROP);

    always_ff @(posedge rx_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser};
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q      <= ST_HDR;
            wr_ptr_q     <= 4'd0;
            sof_ptr_q    <= 4'd0;
            commit_ptr_q <= 4'd0;
            hdr_cnt_q    <= 3'd0;
            pass_q       <= '0;
            drop_q       <= '0;
            runt_q       <= '0;
        end else if (s_axis_tvalid) begin
            case (state_q)
                ST_HDR: begin
                    if (s_axis_tlast) begin
                        wr_ptr_q  <= sof_ptr_q;
                        hdr_cnt_q <= 3'd0;
                        if (runt_q != CNT_MAX) runt_q <= runt_q + CNT_ONE;
                    end else if (hdr_cnt_q == 3'd5) begin
                        hdr_cnt_q <= 3'd0;
                        if (hit) begin
                            wr_ptr_q     <= wr_ptr_q + 4'd1;
                            commit_ptr_q <= wr_ptr_q + 4'd1;
                            state_q      <= ST_PASS;
                            if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_ONE;
                        end else begin
                            wr_ptr_q <= sof_ptr_q;
                            state_q  <= ST_DROP;
                            if (drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
                        end
                    end else begin
                        wr_ptr_q  <= wr_ptr_q + 4'd1;
                        hdr_cnt_q <= hdr_cnt_q + 3'd1;
                    end
                end
                ST_PASS: begin
                    wr_ptr_q     <= wr_ptr_q + 4'd1;
                    commit_ptr_q <= wr_ptr_q + 4'd1;
                    if (s_axis_tlast) begin
                        sof_ptr_q <= wr_ptr_q + 4'd1;
                        hdr_cnt_q <= 3'd0;
                        state_q   <= ST_HDR;
                    end
                end
                default: begin
                    if (s_axis_tlast) state_q <= ST_HDR;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            rd_ptr_q      <= 4'd0;
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (rd_ptr_q != commit_ptr_q) begin
            {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= mem_q[rd_ptr_q];
            m_axis_tvalid <= 1'b1;
            rd_ptr_q      <= rd_ptr_q + 4'd1;
        end else begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign pass_count = pass_q;
    assign drop_count = drop_q;
    assign runt_count = runt_q;

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// tb/tb_eth_rx_addr_filter.sv - directed scoreboard bench for eth_rx_addr_filter
module tb_eth_rx_addr_filter;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_FB;

    logic        rx_clk = 1'b0;
    logic        rx_rst = 1'b1;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [47:0] local_mac = MAC;
    logic        promisc = 1'b0;
    logic        nm_en = 1'b0;
    logic        nm_tvalid;

    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic [15:0] pass_count, drop_count, runt_count;

    logic [7:0]  nm_tdata;
    logic        nm_out_valid, nm_tlast, nm_tuser;
    logic [15:0] nm_pass, nm_drop, nm_runt;

    logic [7:0]  sm_tdata;
    logic        sm_tvalid, sm_tlast, sm_tuser;
    logic [1:0]  sm_pass, sm_drop, sm_runt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nm_outs = 0;
    int exp_pass = 0, exp_drop = 0, exp_runt = 0;
    bit sof_mon = 1'b1;
    logic [9:0] sb [$];
    int lat_q [$];

    assign nm_tvalid = s_tvalid & nm_en;

    always #4 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    eth_rx_addr_filter #(.ENABLE_MULTICAST(1'b1), .CNT_WIDTH(16)) dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .local_mac(local_mac), .promisc(promisc),
        .pass_count(pass_count), .drop_count(drop_count), .runt_count(runt_count));

    eth_rx_addr_filter #(.ENABLE_MULTICAST(1'b0), .CNT_WIDTH(16)) dut_nm (
        .rx_clk(rx_clk), .rx_rst(rx_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(nm_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(nm_tdata), .m_axis_tvalid(nm_out_valid), .m_axis_tlast(nm_tlast), .m_axis_tuser(nm_tuser),
        .local_mac(local_mac), .promisc(promisc),
        .pass_count(nm_pass), .drop_count(nm_drop), .runt_count(nm_runt));

    eth_rx_addr_filter #(.ENABLE_MULTICAST(1'b1), .CNT_WIDTH(2)) dut_sm (
        .rx_clk(rx_clk), .rx_rst(rx_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(sm_tdata), .m_axis_tvalid(sm_tvalid), .m_axis_tlast(sm_tlast), .m_axis_tuser(sm_tuser),
        .local_mac(local_mac), .promisc(promisc),
        .pass_count(sm_pass), .drop_count(sm_drop), .runt_count(sm_runt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat2(input int v);
        return (v > 3) ? 64'd3 : 64'(v);
    endfunction

    // Output monitor: every emitted byte must match the scoreboard head; frame starts check latency.
    always @(negedge rx_clk) begin
        if (!rx_rst && nm_out_valid) nm_outs++;
        if (!rx_rst && m_tvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {m_tdata, m_tlast, m_tuser}, 64'h3FF_DEAD);
            end else begin
                chk("out_byte", {m_tdata, m_tlast, m_tuser}, sb.pop_front());
            end
            if (sof_mon) begin
                if (lat_q.size() == 0) chk("latency_missing", 64'(cyc), 64'hFFFF_FFFF);
                else chk("first_byte_cycle", 64'(cyc), 64'(lat_q.pop_front()));
            end
            sof_mon = m_tlast;
        end
    end

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [47:0] dest, input int len, input bit pass,
                              input bit bad, input int gap);
        logic [7:0] b;
        int n;
        for (int i = 0; i < len; i++) begin
            if (i < 6) b = dest[47-8*i -: 8];
            else b = 8'($urandom);
            s_tdata  = b;
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) && bad;
            s_tvalid = 1'b1;
            if (pass && len > 6) sb.push_back({b, s_tlast, s_tuser});
            @(posedge rx_clk);
            #1;
            if (pass && len > 6 && i == 5) lat_q.push_back(cyc + 1);
            if (gap > 0 && i < len - 1) begin
                n = $urandom_range(0, gap);
                idle(n);
            end
        end
        s_tvalid = 1'b0;
        if (len <= 6) exp_runt++;
        else if (pass) exp_pass++;
        else exp_drop++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        s_tvalid = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge rx_clk);
            #1;
            n++;
        end
        idle(4);
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
        chk({tag, "_pass"}, 64'(pass_count), 64'(exp_pass));
        chk({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
        chk({tag, "_runt"}, 64'(runt_count), 64'(exp_runt));
    endtask

    initial begin
        idle(3);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'({m_tdata, m_tlast, m_tuser}), 64'd0);
        chk("rst_counts", {pass_count, drop_count, runt_count}, 64'd0);
        rx_rst = 1'b0;
        idle(2);

        // 1: unicast match, back-to-back 64 bytes
        send_frame(MAC, 64, 1'b1, 1'b0, 0);
        drain("t1");

        // 2: mismatch dropped, broadcast passes after a 12-cycle gap
        send_frame(OTHER, 64, 1'b0, 1'b0, 0);
        idle(12);
        send_frame(BCAST, 64, 1'b1, 1'b0, 0);
        drain("t2");

        // 3: multicast passes here, dropped by the unicast-only instance
        nm_en = 1'b1;
        send_frame(MCAST, 64, 1'b1, 1'b0, 0);
        nm_en = 1'b0;
        drain("t3");
        chk("nm_drop", 64'(nm_drop), 64'd1);
        chk("nm_pass", 64'(nm_pass), 64'd0);
        chk("nm_no_output", 64'(nm_outs), 64'd0);

        // 4: runts (tlast on byte 3, then byte 5) followed by a good 60-byte frame
        send_frame(MAC, 4, 1'b1, 1'b0, 0);
        send_frame(MAC, 6, 1'b1, 1'b0, 0);
        send_frame(MAC, 60, 1'b1, 1'b0, 0);
        drain("t4");
        send_frame(MAC, 1, 1'b1, 1'b0, 0);
        send_frame(BCAST, 2, 1'b1, 1'b0, 0);
        send_frame(MAC, 5, 1'b1, 1'b0, 0);
        drain("t4b");

        // 5: bad-FCS frame passes with tuser, next frame back-to-back
        send_frame(MAC, 40, 1'b1, 1'b1, 0);
        send_frame(BCAST, 50, 1'b1, 1'b0, 0);
        drain("t5");

        // promiscuous frame with random tvalid gaps, then a gapped drop in non-promisc mode
        promisc = 1'b1;
        send_frame(OTHER, 30, 1'b1, 1'b0, 3);
        promisc = 1'b0;
        send_frame(OTHER, 20, 1'b0, 1'b0, 3);
        send_frame(MAC, 25, 1'b1, 1'b0, 2);
        drain("gaps");

        chk("sat_pass", 64'(sm_pass), sat2(exp_pass));
        chk("sat_drop", 64'(sm_drop), sat2(exp_drop));
        chk("sat_runt", 64'(sm_runt), sat2(exp_runt));

        // 6: reset at byte 30 of a passing frame
        send_frame(MAC, 30, 1'b1, 1'b0, 0);
        rx_rst   = 1'b1;
        s_tvalid = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_rst_counts", {pass_count, drop_count, runt_count}, 64'd0);
        sb.delete();
        lat_q.delete();
        sof_mon  = 1'b1;
        exp_pass = 0;
        exp_drop = 0;
        exp_runt = 0;
        idle(3);
        chk("t6_hold_tvalid", 64'(m_tvalid), 64'd0);
        rx_rst = 1'b0;
        idle(2);
        send_frame(MAC, 64, 1'b1, 1'b0, 0);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_addr_filter.md
Name: eth_rx_addr_filter

Overview:
Destination-MAC filter and frame gate between the RGMII MAC receive AXI-stream output and the RX async FIFO write side, in the rx_clk domain.
It buffers each frame's 6-byte destination address, then decides to pass or drop the frame. Passed frames are forwarded unchanged, including tuser, so the FIFO still drops bad-FCS frames. Dropped and runt frames never reach the FIFO.
Neither interface has backpressure: the MAC cannot stall and the FIFO input is always accepted.

Parameters:
ENABLE_MULTICAST, 1, 1 = pass any destination with I/G bit set (byte0[0]=1); 0 = pass only unicast match and broadcast.
CNT_WIDTH, 16, width of the status counters.

Ports:
rx_clk  in  1  receive clock.
rx_rst  in  1  reset; asynchronous, active-high.
s_axis_tdata  in  8  byte from MAC.
s_axis_tvalid  in  1  byte valid.
s_axis_tlast  in  1  last byte of frame.
s_axis_tuser  in  1  bad frame, meaningful with tlast.
m_axis_tdata  out  8  byte to RX FIFO.
m_axis_tvalid  out  1  byte valid.
m_axis_tlast  out  1  last byte.
m_axis_tuser  out  1  bad frame flag, passed through.
local_mac  in  48  station address; [47:40] is the first byte on the wire. Quasi-static.
promisc  in  1  1 = pass every frame that is not a runt. Quasi-static.
pass_count  out  CNT_WIDTH  frames passed, saturating.
drop_count  out  CNT_WIDTH  frames dropped on address mismatch, saturating.
runt_count  out  CNT_WIDTH  frames dropped as runts, saturating.

Behaviour:
- Storage: 16-entry circular buffer of {tdata,tlast,tuser}. Pointers are 4-bit and wrap modulo 16.
  - wr_ptr: next write slot.
  - sof_ptr: first byte of the current frame.
  - commit_ptr: end of readable data.
  - rd_ptr: next read slot.
- Write-side FSM states: HDR, PASS, DROP. Reset state is HDR with hdr_cnt=0.
- HDR:
  - Each valid byte is written at wr_ptr, wr_ptr increments, hdr_cnt increments.
  - Byte with tlast while hdr_cnt is 0..5 (includes tlast on byte 5): runt. wr_ptr<=sof_ptr, runt_count+1, hdr_cnt<=0, stay in HDR.
  - Byte 5 without tlast: decide in the same edge, using byte 5 from the input and bytes 0..4 from the buffer. Dest is byte0..byte5, byte0 most significant.
  - Match = promisc | dest==local_mac | dest==48'hFFFFFFFFFFFF | (ENABLE_MULTICAST & byte0[0]).
  - On match: commit_ptr<=wr_ptr+1, pass_count+1, go to PASS.
  - On no match: wr_ptr<=sof_ptr, drop_count+1, go to DROP.
- PASS: each valid byte is written, and wr_ptr and commit_ptr both advance. On tlast: sof_ptr<=wr_ptr+1, hdr_cnt<=0, go to HDR.
- DROP: valid bytes are discarded. On tlast: go to HDR with sof_ptr unchanged.
- Read side: each cycle with rd_ptr!=commit_ptr, register the entry onto m_axis_*, assert m_axis_tvalid for one cycle, rd_ptr+1. Otherwise m_axis_tvalid=0.
- Latency: byte 5 accepted at edge T → byte 0 appears on m_axis at edge T+1, then one byte per cycle. Steady-state input-to-output delay is 6 cycles at 1G back-to-back.
- Occupancy bound:
  - Committed backlog is at most 6 and uncommitted data is at most 6, so at most 12 of 16 entries are used. Overflow is impossible; no full flag.
  - A new frame may enter HDR while the previous frame is still draining. The read side is unaffected.
- Sampling: local_mac and promisc are sampled only at the byte-5 decision.
- Counters: each saturates at all-ones. A simultaneous decision and read has no interaction.
- Reset (asynchronous assert): all pointers 0, state HDR, hdr_cnt 0, all counters 0, m_axis_tdata/tvalid/tlast/tuser 0.
  - Buffered data is lost and no partial frame is emitted.
  - The MAC shares rx_rst, so the first valid byte after deassertion is byte 0 of a frame.
- Gaps: tvalid gaps of any length (10/100 operation) inside any state leave all state unchanged.

Test Plan:
1. local_mac=02:00:00:00:00:01, promisc=0, 64-byte frame to 02:00:00:00:00:01, back-to-back → identical 64 bytes out, byte 0 valid one cycle after input byte 5, tlast on byte 63, pass_count=1.
2. Frame to 02:00:00:00:00:02, then broadcast frame after a 12-cycle gap → first frame produces no m_axis_tvalid, drop_count=1; broadcast frame passes, pass_count=1.
3. ENABLE_MULTICAST=1: dest 01:00:5E:00:00:FB → passes. ENABLE_MULTICAST=0: same frame → drop_count=1.
4. 4-byte frame (tlast on byte 3), then a 6-byte frame (tlast on byte 5), then a valid 60-byte frame → runt_count=2, only the 60-byte frame output, byte-exact.
5. Passed frame with tuser=1 on tlast → forwarded with m_axis_tuser=1 on the last byte. Next frame starts 1 cycle after tlast and is passed → both frames are emitted intact and in order.
6. Assert rx_rst at byte 30 of a passing frame → m_axis_tvalid=0 and counters=0 immediately. After release, a new 64-byte matching frame passes intact.
